// File: rtl/rv_iommu_pdt_walker_pkg.sv
// rv_iommu package: types and constants shared by the PDT walker.
//   pc_t          - Process Context as stored in the PDTC (ta, fsc)
//   pdtp_mode_e   - pdtp.MODE encodings
//   pdtw_state_e  - walker FSM states
//   CAUSE_PDT_*   - fault causes reported to the fault queue
package rv_iommu;

  typedef struct packed {
    logic [63:0] ta;
    logic [63:0] fsc;
  } pc_t;

  typedef enum logic [3:0] {
    PDTP_BARE = 4'd0,
    PDTP_PD8  = 4'd1,
    PDTP_PD17 = 4'd2,
    PDTP_PD20 = 4'd3
  } pdtp_mode_e;

  typedef enum logic [3:0] {
    PDTW_IDLE,
    PDTW_NL_REQ,
    PDTW_NL_WAIT,
    PDTW_TA_REQ,
    PDTW_TA_WAIT,
    PDTW_FSC_REQ,
    PDTW_FSC_WAIT,
    PDTW_UPDATE,
    PDTW_FAULT
  } pdtw_state_e;

  localparam logic [11:0] CAUSE_PDT_LD_FAULT = 12'd265;
  localparam logic [11:0] CAUSE_PDT_INVALID  = 12'd266;
  localparam logic [11:0] CAUSE_PDT_MISCONF  = 12'd267;

endpackage

// File: rtl/rv_iommu_pdtw_addr.sv
// PDT walker address generator (combinational).
// Selects the process_id index for the current level and forms the
// 8-byte aligned read address.
//   i_level : non-leaf level (2 -> pid[19:17], 1 -> pid[16:8])
//   i_pid   : process_id of the walk
//   i_ppn   : page number of the table being read
//   i_leaf  : reading the leaf Process Context (index pid[7:0], 16 B entries)
//   i_fsc   : second (fsc) word of the leaf entry
//   o_addr  : read address
module rv_iommu_pdtw_addr #(
  parameter int ADDR_W = 56,
  parameter int PPN_W  = 44
) (
  input  logic [1:0]        i_level,
  input  logic [19:0]       i_pid,
  input  logic [PPN_W-1:0]  i_ppn,
  input  logic              i_leaf,
  input  logic              i_fsc,
  output logic [ADDR_W-1:0] o_addr
);

  logic [8:0]        w_idx;
  logic [11:0]       w_off;
  logic [ADDR_W-1:0] w_base;

  always_comb begin
    w_idx  = (i_level == 2'd2) ? {6'd0, i_pid[19:17]} : i_pid[16:8];
    // Leaf entries are two words wide: idx*16, plus 8 for the fsc word.
    w_off  = i_leaf ? {i_pid[7:0], i_fsc, 3'b000} : {w_idx, 3'b000};
    w_base = ADDR_W'({i_ppn, 12'h000});
    o_addr = w_base + ADDR_W'(w_off);
  end

endmodule

// File: rtl/rv_iommu_pdt_walker.sv
// Process Directory Table walker.
// On a PDTC miss it walks the 1..3 level PDT rooted at pdtp_ppn_i, one
// 64-bit read at a time, and either fills the PDTC (update_o + up_*) or
// reports a fault cause. A flush that hits the walk's device_id marks the
// walk stale: it still drains its read but finishes without update_o.
// Optional: define RV_IOMMU_PDTW_RSV_CHECK_EN to fault (cause 267) on
// nonzero reserved bits in non-leaf entries and in the ta word.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   req_i, req_did_i, req_pid_i, pdtp_mode_i, pdtp_ppn_i : walk request
//   busy_o                                               : walk in progress
//   mem_req_o/mem_addr_o/mem_gnt_i                       : read request
//   mem_rvalid_i/mem_rdata_i/mem_err_i                   : read response
//   flush_i/flush_dv_i/flush_did_i                       : invalidation
//   update_o/up_did_o/up_pid_o/up_content_o              : PDTC fill
//   done_o/fault_o/cause_o                               : completion
module rv_iommu_pdt_walker
  import rv_iommu::*;
#(
  parameter int ADDR_W = 56,
  parameter int PPN_W  = 44
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [23:0]       req_did_i,
  input  logic [19:0]       req_pid_i,
  input  logic [3:0]        pdtp_mode_i,
  input  logic [PPN_W-1:0]  pdtp_ppn_i,
  output logic              busy_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [63:0]       mem_rdata_i,
  input  logic              mem_err_i,
  input  logic              flush_i,
  input  logic              flush_dv_i,
  input  logic [23:0]       flush_did_i,
  output logic              update_o,
  output logic [23:0]       up_did_o,
  output logic [19:0]       up_pid_o,
  output pc_t               up_content_o,
  output logic              done_o,
  output logic              fault_o,
  output logic [11:0]       cause_o
);

  pdtw_state_e       r_state, w_state_n;
  logic [1:0]        r_level;
  logic [23:0]       r_did;
  logic [19:0]       r_pid;
  logic [PPN_W-1:0]  r_ppn;
  logic [63:0]       r_ta, r_fsc;
  logic [11:0]       r_cause, w_cause_n;
  logic              r_stale;
  logic              w_flush_hit, w_nl_rsv, w_ta_rsv, w_leaf;
  logic [ADDR_W-1:0] w_addr;

`ifdef RV_IOMMU_PDTW_RSV_CHECK_EN
  assign w_nl_rsv = (|mem_rdata_i[9:1]) | (|mem_rdata_i[63:54]);
  assign w_ta_rsv = (|mem_rdata_i[11:1]) | (|mem_rdata_i[63:32]);
`else
  assign w_nl_rsv = 1'b0;
  assign w_ta_rsv = 1'b0;
`endif

  assign w_flush_hit = flush_i & (~flush_dv_i | (flush_did_i == r_did));
  assign w_leaf      = (r_state == PDTW_TA_REQ) | (r_state == PDTW_FSC_REQ);

  rv_iommu_pdtw_addr #(.ADDR_W(ADDR_W), .PPN_W(PPN_W)) u_addr (
    .i_level (r_level),
    .i_pid   (r_pid),
    .i_ppn   (r_ppn),
    .i_leaf  (w_leaf),
    .i_fsc   (r_state == PDTW_FSC_REQ),
    .o_addr  (w_addr)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= PDTW_IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_cause_n = r_cause;
    case (r_state)
      PDTW_IDLE: if (req_i) begin
        case (pdtp_mode_i)
          PDTP_PD8:
            if (|req_pid_i[19:8]) begin
              w_state_n = PDTW_FAULT;
              w_cause_n = CAUSE_PDT_INVALID;
            end else w_state_n = PDTW_TA_REQ;
          PDTP_PD17:
            if (|req_pid_i[19:17]) begin
              w_state_n = PDTW_FAULT;
              w_cause_n = CAUSE_PDT_INVALID;
            end else w_state_n = PDTW_NL_REQ;
          PDTP_PD20: w_state_n = PDTW_NL_REQ;
          default: begin
            w_state_n = PDTW_FAULT;
            w_cause_n = CAUSE_PDT_MISCONF;
          end
        endcase
      end
      PDTW_NL_REQ:  if (mem_gnt_i) w_state_n = PDTW_NL_WAIT;
      PDTW_NL_WAIT: if (mem_rvalid_i) begin
        if (mem_err_i) begin
          w_state_n = PDTW_FAULT;
          w_cause_n = CAUSE_PDT_LD_FAULT;
        end else if (!mem_rdata_i[0]) begin
          w_state_n = PDTW_FAULT;
          w_cause_n = CAUSE_PDT_INVALID;
        end else if (w_nl_rsv) begin
          w_state_n = PDTW_FAULT;
          w_cause_n = CAUSE_PDT_MISCONF;
        end else begin
          // r_level is the level just read; level 1 leads to the leaf.
          w_state_n = (r_level == 2'd1) ? PDTW_TA_REQ : PDTW_NL_REQ;
        end
      end
      PDTW_TA_REQ:  if (mem_gnt_i) w_state_n = PDTW_TA_WAIT;
      PDTW_TA_WAIT: if (mem_rvalid_i) begin
        if (mem_err_i) begin
          w_state_n = PDTW_FAULT;
          w_cause_n = CAUSE_PDT_LD_FAULT;
        end else if (!mem_rdata_i[0]) begin
          w_state_n = PDTW_FAULT;
          w_cause_n = CAUSE_PDT_INVALID;
        end else if (w_ta_rsv) begin
          w_state_n = PDTW_FAULT;
          w_cause_n = CAUSE_PDT_MISCONF;
        end else w_state_n = PDTW_FSC_REQ;
      end
      PDTW_FSC_REQ:  if (mem_gnt_i) w_state_n = PDTW_FSC_WAIT;
      PDTW_FSC_WAIT: if (mem_rvalid_i) begin
        if (mem_err_i) begin
          w_state_n = PDTW_FAULT;
          w_cause_n = CAUSE_PDT_LD_FAULT;
        end else w_state_n = PDTW_UPDATE;
      end
      PDTW_UPDATE: w_state_n = PDTW_IDLE;
      PDTW_FAULT:  w_state_n = PDTW_IDLE;
      default:     w_state_n = PDTW_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_level <= '0;
      r_did   <= '0;
      r_pid   <= '0;
      r_ppn   <= '0;
      r_ta    <= '0;
      r_fsc   <= '0;
      r_cause <= '0;
      r_stale <= 1'b0;
    end else begin
      r_cause <= w_cause_n;
      case (r_state)
        PDTW_IDLE: if (req_i) begin
          r_did   <= req_did_i;
          r_pid   <= req_pid_i;
          r_ppn   <= pdtp_ppn_i;
          r_level <= (pdtp_mode_i == PDTP_PD20) ? 2'd2 :
                     (pdtp_mode_i == PDTP_PD17) ? 2'd1 : 2'd0;
          // A flush coinciding with acceptance already invalidates this walk.
          r_stale <= flush_i & (~flush_dv_i | (flush_did_i == req_did_i));
        end
        PDTW_NL_WAIT:
          if ((w_state_n == PDTW_NL_REQ) || (w_state_n == PDTW_TA_REQ)) begin
            r_ppn   <= mem_rdata_i[10 +: PPN_W];
            r_level <= r_level - 2'd1;
          end
        PDTW_TA_WAIT:  if (w_state_n == PDTW_FSC_REQ) r_ta  <= mem_rdata_i;
        PDTW_FSC_WAIT: if (w_state_n == PDTW_UPDATE)  r_fsc <= mem_rdata_i;
        default: ;
      endcase
      if ((r_state != PDTW_IDLE) && w_flush_hit) r_stale <= 1'b1;
    end
  end

  assign busy_o       = (r_state != PDTW_IDLE);
  assign mem_req_o    = (r_state == PDTW_NL_REQ) | w_leaf;
  assign mem_addr_o   = mem_req_o ? w_addr : '0;
  // A flush in the UPDATE cycle itself must still suppress the fill.
  assign update_o     = (r_state == PDTW_UPDATE) & ~r_stale & ~w_flush_hit;
  assign done_o       = (r_state == PDTW_UPDATE) | (r_state == PDTW_FAULT);
  assign fault_o      = (r_state == PDTW_FAULT);
  assign cause_o      = fault_o ? r_cause : 12'd0;
  assign up_did_o     = r_did;
  assign up_pid_o     = r_pid;
  assign up_content_o = '{ta: r_ta, fsc: r_fsc};

endmodule

// File: doc/rv_iommu_pdt_walker.md
Name: rv_iommu_pdt_walker

Overview:
Process Directory Table walker for the IOMMU translation logic. It takes a PDTC lookup miss (device_id, process_id, pdtp from the Device Context) and walks the 1 to 3 level PDT in memory. Each read is issued on a single 64-bit read port. On success it produces the update_i/up_did_i/up_pid_i/up_content_i bundle that fills the PDTC; otherwise it reports a fault cause to the fault queue.

Parameters:
- ADDR_W, 56, physical address width of the memory port.
- PPN_W, 44, PPN width taken from pdtp and non-leaf PDT entries.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_i  in  1  start walk; sampled only in IDLE
- req_did_i  in  24  device_id of the miss
- req_pid_i  in  20  process_id of the miss
- pdtp_mode_i  in  4  0=Bare, 1=PD8, 2=PD17, 3=PD20, others reserved
- pdtp_ppn_i  in  PPN_W  root PDT page
- busy_o  out  1  walk in progress
- mem_req_o  out  1  read request
- mem_addr_o  out  ADDR_W  8-byte aligned read address
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  64  read data
- mem_err_i  in  1  bus error, qualified by mem_rvalid_i
- flush_i  in  1  IODIR.INVAL_DDT/INVAL_PDT strobe
- flush_dv_i  in  1  flush targets flush_did_i only
- flush_did_i  in  24  device_id to flush
- update_o  out  1  one-cycle PDTC fill strobe
- up_did_o  out  24  device_id for the fill
- up_pid_o  out  20  process_id for the fill
- up_content_o  out  rv_iommu::pc_t  Process Context (ta, fsc)
- done_o  out  1  one-cycle walk-complete strobe (success, fault or discard)
- fault_o  out  1  qualifies done_o
- cause_o  out  12  fault cause, valid when fault_o=1

Behaviour:
- Reset values: all outputs 0, state IDLE, level counter 0. A reset mid-walk abandons the walk: no update_o, no done_o, and any outstanding rvalid is ignored after reset.
- Levels by mode:
  - PD20: idx2=pid[19:17], idx1=pid[16:8], idx0=pid[7:0].
  - PD17: idx1=pid[16:8], idx0=pid[7:0].
  - PD8: idx0=pid[7:0].
- Address computation:
  - Non-leaf: (ppn<<12) + idx*8.
  - Leaf: (ppn<<12) + idx*16 for the ta word, +8 for the fsc word.
- Out-of-range pid: PD8 with pid[19:8]!=0, or PD17 with pid[19:17]!=0, goes to FAULT with cause 266 without issuing any read.
- Bare or reserved mode goes to FAULT with cause 267.
- FSM states: IDLE, NL_REQ, NL_WAIT, TA_REQ, TA_WAIT, FSC_REQ, FSC_WAIT, UPDATE, FAULT.
  - IDLE: on req_i, latch did/pid/mode/ppn and go to NL_REQ, or to TA_REQ if PD8.
  - *_REQ: mem_req_o held high with a stable address until mem_gnt_i, then go to *_WAIT. Only one request is outstanding at a time.
  - NL_WAIT on rvalid:
    - err -> FAULT 265.
    - rdata[0]=0 -> FAULT 266.
    - otherwise ppn=rdata[53:10], decrement level; level 0 -> TA_REQ, else NL_REQ.
  - TA_WAIT on rvalid:
    - err -> FAULT 265.
    - rdata[0] (ta.V)=0 -> FAULT 266.
    - otherwise latch ta and go to FSC_REQ.
  - FSC_WAIT on rvalid: err -> FAULT 265; else latch fsc and go to UPDATE.
  - UPDATE: update_o=1 and done_o=1 for one cycle, then IDLE.
  - FAULT: done_o=1, fault_o=1, cause_o valid for one cycle, then IDLE.
- Earliest request: mem_req_o rises in the cycle after req_i is accepted; busy_o is high from that cycle through the done_o cycle.
- Minimum PD8 latency is 5 cycles from req_i to update_o, with gnt and rvalid each arriving 1 cycle after request.
- Flush mid-walk: a flush with flush_dv_i=0, or a flush whose flush_did_i equals the latched did, sets a stale flag.
  - The walk still drains its outstanding read.
  - UPDATE then asserts done_o with update_o=0.
  - A fault on a stale walk is still reported.
- A flush arriving in the same cycle as UPDATE suppresses update_o.
- req_i while busy_o=1 is ignored; the upstream holds it.

Optional Feature:
- Macro RV_IOMMU_PDTW_RSV_CHECK_EN.
- When defined:
  - A non-leaf entry with nonzero reserved bits [9:1] or [63:54] faults with cause 267.
  - A ta word with nonzero reserved bits [11:1] or [63:32] faults with cause 267.
- When undefined: reserved bits are ignored.

Decomposition:
- rv_iommu package holds:
  - pc_t (existing).
  - New pdtp_mode_e.
  - PDTW_STATE_E.
  - Cause constants CAUSE_PDT_LD_FAULT=265, CAUSE_PDT_INVALID=266, CAUSE_PDT_MISCONF=267.
- Sub-module rv_iommu_pdtw_addr: combinational index select and address generation from mode, level, pid, ppn and the leaf/fsc flag.

Test Plan:
- PD8, pdtp_ppn=0x1000, pid=0x05: reads 0x1000050 and 0x1000058, ta=0x...0001, fsc=0x8000_0000_0002_0000 -> update_o with up_pid_o=0x05 and matching content, fault_o=0.
- PD20, pid=0xA1234: reads at root+5*8, then nl1+0x12*8, then leaf+0x34*16 -> exactly 4 requests, then one update_o.
- PD17, second-level entry rdata[0]=0 -> done_o, fault_o=1, cause_o=266, no TA read.
- TA read returns mem_err_i=1 -> cause_o=265; PD8 with pid=0x100 -> cause_o=266 with zero memory requests.
- flush_i with flush_dv_i=1 and a matching did during TA_WAIT -> done_o=1, update_o=0; a non-matching did -> normal update.
- With RV_IOMMU_PDTW_RSV_CHECK_EN defined, a non-leaf entry 0x...0003 -> cause_o=267; undefined -> the walk proceeds.
